store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Store-side counterpart of the load data extractor: takes sb/sh/sw from the MEM stage, generates
//  byte enables and lane-replicated write data, and flags misaligned stores (AdES).
//  Queues aligned stores in a small FIFO and drains them to data memory over a req/ack handshake.
//  Also reports load-after-store word hazards so the pipeline can stall dependent loads.
// PARAMETERS
//  DEPTH  4  store queue entries; power of two, >= 2
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   MEM stage presents a store
//  in_ready     out  1   queue can accept; =!full
//  in_addr      in   32  byte address of store
//  in_data      in   32  rt register value (data in low bits)
//  in_op        in   2   00 sw, 01 sb, 11 sh (10 reserved: treated as sw)
//  ade_err      out  1   one-cycle pulse: misaligned store rejected
//  ade_badaddr  out  32  in_addr of last rejected store (BadVAddr)
//  mem_req      out  1   head entry valid, write requested
//  mem_ack      in   1   memory accepts head write this cycle
//  mem_addr     out  32  {head_addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated data of head entry
//  mem_be       out  4   byte enables of head entry; bit i = byte lane i (bits 8i+7:8i)
//  ld_addr      in   32  address of load currently in MEM stage
//  ld_hazard    out  1   some queued entry targets the same word as ld_addr
//  empty        out  1   queue holds no entries
// BEHAVIOUR
//  Reset: queue emptied, rd/wr pointers and count 0; mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0,
//   ade_err=0, ade_badaddr=0, ld_hazard=0, empty=1, in_ready=1. Reset mid-drain abandons the
//   outstanding write; mem_req drops immediately (async), memory must ignore a stale ack.
//  Lane generation (combinational on in_*):
//   sb: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}
//   sh: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}
//   sw: be=4'b1111, wdata=data
//  Misalign: sh with addr[0]=1, or sw with addr[1:0]!=0. Such a store is handshaken
//   (consumed when in_valid&&in_ready) but never enqueued; next cycle ade_err=1 for exactly one
//   cycle and ade_badaddr holds in_addr. Misaligned store while full: not consumed, no error yet.
//  Push: in_valid&&in_ready&&aligned -> entry {addr,wdata,be} written at wr_ptr, count+1.
//  Pop: mem_req&&mem_ack -> rd_ptr+1, count-1. mem_* outputs driven from head registers (0 latency
//   from entry becoming head); held stable while mem_req=1 and mem_ack=0.
//  Simultaneous push+pop: allowed when not full; count unchanged. When full, in_ready=0 even if
//   mem_ack=1 that cycle (no same-cycle bypass).
//  Empty: mem_req=0, mem_be=4'b0000, mem_addr/mem_wdata hold last values; a push to empty queue
//   raises mem_req the following cycle (1-cycle enqueue->request latency).
//  Pointers: log2(DEPTH) bits, wrap naturally; count 0..DEPTH, log2(DEPTH)+1 bits.
//  ld_hazard: combinational OR over valid entries of (entry.addr[31:2]==ld_addr[31:2]); excludes a
//   store being pushed the same cycle; entry popped this cycle still counts until the edge.
//  Stores complete to memory strictly in program order.
// STRUCTURE
//  Package mips_mem_pkg: ST_OP_SW/SB/SH encodings, BE_BYTE0, BE_HALF_LO/HI, BE_WORD constants,
//   store_entry_t {addr[31:0], wdata[31:0], be[3:0]}.
//  Sub-module store_lane_gen: combinational op/addr/data -> be, wdata, misalign.
//  FIFO storage, pointers, handshake and hazard compare stay in store_buffer.
// TESTING
//  1 sb addr=0x1003 data=0x000000AB -> mem_addr=0x1000, be=1000, wdata=0xABABABAB, then ack pops.
//  2 sh addr=0x2002 data=0x1234 -> be=1100, wdata=0x12341234; sh addr=0x2001 -> ade_err 1 cycle,
//    ade_badaddr=0x2001, no mem_req.
//  3 Hold mem_ack=0, push 4 sw -> in_ready=0 after 4th; 5th held; one ack + push same cycle while
//    full -> 5th not accepted until next cycle; order of 4 writes preserved.
//  4 Queue sw 0x3000; ld_addr=0x3002 -> ld_hazard=1; ld_addr=0x3004 -> 0; after ack pop -> 0.
//  5 Continuous push+ack every cycle for 2*DEPTH stores -> count stays 1, pointers wrap, no loss.
//  6 Assert rst_n=0 with 3 entries, mem_req=1 -> mem_req=0 same cycle, empty=1, in_ready=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings and types for the MEM-stage store path.
package mips_mem_pkg;

  localparam logic [1:0] ST_OP_SW = 2'b00;
  localparam logic [1:0] ST_OP_SB = 2'b01;
  localparam logic [1:0] ST_OP_SH = 2'b11;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-in, memory-drain and load-hazard signals of the store buffer.
interface store_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        ade_err;
  logic [31:0] ade_badaddr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;

  modport slave (
    input  in_valid, in_addr, in_data, in_op, mem_ack, ld_addr,
    output in_ready, ade_err, ade_badaddr, mem_req, mem_addr, mem_wdata, mem_be,
           ld_hazard, empty
  );

  modport master (
    output in_valid, in_addr, in_data, in_op, mem_ack, ld_addr,
    input  in_ready, ade_err, ade_badaddr, mem_req, mem_addr, mem_wdata, mem_be,
           ld_hazard, empty
  );
endinterface

// File: rtl/store_lane_gen.sv
// Byte enables, lane-replicated write data and misalignment for sb/sh/sw.
module store_lane_gen
  import mips_mem_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // Reserved op 2'b10 falls through to the word case.
  always_comb begin
    be       = BE_WORD;
    wdata    = data;
    misalign = (addr != 2'b00);
    case (op)
      ST_OP_SB: begin
        be       = BE_BYTE0 << addr;
        wdata    = {4{data[7:0]}};
        misalign = 1'b0;
      end
      ST_OP_SH: begin
        be       = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata    = {2{data[15:0]}};
        misalign = addr[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: lane generation, AdES detection, req/ack drain and load hazard check.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [3:0]   lane_be;
  logic [31:0]  lane_wdata;
  logic         misalign;
  logic         full, accept, push, pop;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  store_entry_t entries_q [DEPTH];
  store_entry_t new_entry, head_q, head_d;
  logic         ade_err_q;
  logic [31:0]  ade_badaddr_q;
  logic [PtrW-1:0] offset;
  logic         hazard;

  store_lane_gen u_lane_gen (
    .op       (bus.in_op),
    .addr     (bus.in_addr[1:0]),
    .data     (bus.in_data),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .misalign (misalign)
  );

  assign full      = (count_q == CntW'(DEPTH));
  assign accept    = bus.in_valid && !full;
  assign push      = accept && !misalign;
  assign pop       = (count_q != '0) && bus.mem_ack;
  assign new_entry = '{addr: bus.in_addr, wdata: lane_wdata, be: lane_be};

  // Head registers track the entry that will be at rd_ptr after this edge; an entry pushed into
  // an effectively empty queue is forwarded so it requests one cycle after enqueue.
  always_comb begin
    count_d   = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    head_d    = head_q;
    head_d.be = '0;
    if (count_d != '0) begin
      head_d = (push && count_q == CntW'(pop)) ? new_entry : entries_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      ade_err_q     <= 1'b0;
      ade_badaddr_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_q + PtrW'(push);
      count_q   <= count_d;
      head_q    <= head_d;
      ade_err_q <= accept && misalign;
      if (accept && misalign) ade_badaddr_q <= bus.in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries_q[wr_ptr_q] <= new_entry;
  end

  // An entry is live when its distance from rd_ptr is below count.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PtrW'(i) - rd_ptr_q;
      if ((CntW'(offset) < count_q) && (entries_q[i].addr[31:2] == bus.ld_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  assign bus.in_ready    = !full;
  assign bus.mem_req     = (count_q != '0);
  assign bus.empty       = (count_q == '0);
  assign bus.mem_addr    = {head_q.addr[31:2], 2'b00};
  assign bus.mem_wdata   = head_q.wdata;
  assign bus.mem_be      = head_q.be;
  assign bus.ade_err     = ade_err_q;
  assign bus.ade_badaddr = ade_badaddr_q;
  assign bus.ld_hazard   = hazard;

endmodule
